// File: rtl/buffer_pkg.sv
// ---------------------------------------------------------------------------
// buffer_pkg
// Shared constants and helpers for the stream FIFO buffer.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and entry count
//   ptr_width()                   : pointer width for a given depth, i.e.
//                                   index bits plus one wrap bit
// ---------------------------------------------------------------------------
package buffer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Index bits plus a wrap bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/buffer_mem.sv
// ---------------------------------------------------------------------------
// buffer_mem
// DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk    : rising-edge clock
//   we     : write enable, wdata stored at waddr on the clock edge
//   waddr  : write index
//   wdata  : write word
//   raddr  : read index
//   rdata  : combinational read of the entry at raddr
// ---------------------------------------------------------------------------
module buffer_mem
    import buffer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [ptr_width(DEPTH)-2:0]    waddr,
    input  logic [WIDTH-1:0]               wdata,
    input  logic [ptr_width(DEPTH)-2:0]    raddr,
    output logic [WIDTH-1:0]               rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stream_fifo_buffer.sv
// ---------------------------------------------------------------------------
// stream_fifo_buffer
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data: producer side; s_ready = !full
//   m_valid/m_ready/m_data: consumer side; m_valid = !empty, m_data is the
//                           oldest word, zero when empty
//   level, almost_full    : word count and level >= AF_THRESH; present only
//                           when the BUFFER_LEVEL_EN macro is defined
// ---------------------------------------------------------------------------
module stream_fifo_buffer
    import buffer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH
`ifdef BUFFER_LEVEL_EN
    ,
    parameter int AF_THRESH = DEPTH - 1
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [WIDTH-1:0]              s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0]              m_data
`ifdef BUFFER_LEVEL_EN
    ,
    output logic [ptr_width(DEPTH)-1:0]   level,
    output logic                          almost_full
`endif
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             empty, full;
    logic             push, pop;
    logic [WIDTH-1:0] rdata;

    // Flags come only from registered pointers, so s_ready and m_valid have
    // no combinational path from s_valid or m_ready.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign s_ready = ~full;
    assign m_valid = ~empty;

    // A pop while full does not open the input in the same cycle.
    assign push = s_valid & ~full;
    assign pop  = m_ready & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (s_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (rdata)
    );

    // Storage is never cleared, so stale contents are hidden while empty.
    assign m_data = empty ? '0 : rdata;

`ifdef BUFFER_LEVEL_EN
    // Modulo subtraction across the wrap bit yields 0..DEPTH.
    assign level       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (level >= PW'(AF_THRESH));
`endif

endmodule

// File: doc/stream_fifo_buffer.md
# stream_fifo_buffer

Parametrised synchronous FIFO buffer with valid/ready handshaking on both sides, replacing the single-bit pass-through buffer wherever a producer and consumer must be decoupled by storage. It accepts WIDTH-bit words, holds up to DEPTH of them, and presents the oldest word first-word-fall-through. It sits between any two streaming stages sharing one clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, storage entries; power of two, ≥2
- AF_THRESH, DEPTH-1, level at or above which almost_full asserts (only with BUFFER_LEVEL_EN)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- s_valid  input  1  producer offers s_data
- s_ready  output  1  buffer can accept; equals !full
- s_data  input  WIDTH  write word
- m_valid  output  1  buffer holds at least one word; equals !empty
- m_ready  input  1  consumer takes m_data
- m_data  output  WIDTH  oldest stored word; all-zero when empty
- level  output  $clog2(DEPTH)+1  current word count (BUFFER_LEVEL_EN only)
- almost_full  output  1  level ≥ AF_THRESH (BUFFER_LEVEL_EN only)

## Operation
- Push = s_valid & s_ready at a rising clk edge; pop = m_valid & m_ready at a rising clk edge.
- Write pointer and read pointer, each $clog2(DEPTH)+1 bits; low bits index storage, MSB is the wrap bit.
- empty when pointers are equal; full when low bits are equal and MSBs differ.
- Push: store s_data at wr_ptr, wr_ptr+1. Pop: rd_ptr+1. Pointers wrap naturally modulo 2·DEPTH.
- Simultaneous push and pop (neither full nor empty): both occur; count unchanged.
- Full: s_ready=0; s_valid is ignored, no data lost from storage, no pointer change. A pop in the same cycle does not enable a push that cycle (no pass-through of ready).
- Empty: m_valid=0, m_data=0; m_ready ignored. A push into an empty buffer is not forwarded combinationally.
- s_data need not hold while s_valid is low; the producer must hold s_valid/s_data until accepted. m_data/m_valid are stable until popped.
- Reset (async assert, any time incl. mid-transfer): both pointers 0, contents discarded; outputs immediately s_ready=1, m_valid=0, m_data=0, level=0, almost_full=0 (almost_full=1 only if AF_THRESH=0). Storage array is not reset.

## Timing
- Write-to-read latency: word pushed at edge k is on m_data with m_valid=1 immediately after edge k (one cycle).
- Throughput: one push and one pop per cycle sustained.
- s_ready, m_valid, level, almost_full change only after clk edges or on rst_n assertion; all are functions of registered pointers only, with no combinational path from s_valid/m_ready.
- m_data is a combinational read of registered storage at rd_ptr, masked to zero when empty.
- Reset release is synchronised by the environment; first push may occur at the first edge after rst_n rises.

## Configuration
- BUFFER_LEVEL_EN defined: level and almost_full ports exist; level = wr_ptr − rd_ptr (pointer width, modulo), range 0..DEPTH.
- Not defined: both ports and their logic are absent; all other behaviour identical.

## Structure
- Package buffer_pkg: clog2-based pointer-width helper function and default WIDTH/DEPTH constants.
- One sub-module, buffer_mem: DEPTH×WIDTH storage with one synchronous write port and one asynchronous read port; pointer/flag logic stays in stream_fifo_buffer.

## Test plan
- Reset: rst_n low mid-stream with 3 words stored -> immediately m_valid=0, m_data=0, s_ready=1, level=0; after release, first pop returns only newly pushed data.
- Fill: WIDTH=8, DEPTH=4, push 0x11,0x22,0x33,0x44 with m_ready=0 -> s_ready=0 after 4th edge, level=4, almost_full=1 from level 3; 5th word 0x55 held by producer is not stored.
- Drain order: from full, m_ready=1 for 4 cycles -> m_data 0x11,0x22,0x33,0x44 in order, then m_valid=0, m_data=0.
- Streaming: s_valid=m_ready=1 for 20 cycles with incrementing data -> outputs match inputs one cycle later, level constant at 1, no drops.
- Wrap-around: 3·DEPTH pushes/pops with random m_ready stalls -> scoreboard matches, pointers wrap without spurious full/empty.
- Full + pop same cycle: at level 4, s_valid=1, m_ready=1 -> pop occurs, push does not; level=3 next cycle, s_ready=1.
